// File: rtl/ccip_af_pipe_reg.sv
// ccip_af_pipe_reg: multi-channel CCI-P Tx request pipeline with one register
// pipe and one skid FIFO per channel. Each channel raises its own almost-full.
//
// Ports:
//   clk, reset (async, active-high)
//   in_valid[NUM_CH], in_data[NUM_CH*DATA_W]   requests from the AFU
//   in_almost_full[NUM_CH]                     registered backpressure to AFU
//   out_valid[NUM_CH], out_data[NUM_CH*DATA_W] registered requests to FIU
//   out_almost_full[NUM_CH]                    FIU backpressure
//   overflow[NUM_CH]                           sticky write-into-full flag
//   stat_accepted[NUM_CH*32], stat_max_occ[NUM_CH*8]
//     These are counters when CCIP_AF_PIPE_STATS_EN is defined.
//     Otherwise they are tied to 0.
module ccip_af_pipe_reg #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 600,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 32,
  parameter int AF_SLACK    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_almost_full,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_almost_full,
  output logic [NUM_CH-1:0]        overflow,
  output logic [NUM_CH*32-1:0]     stat_accepted,
  output logic [NUM_CH*8-1:0]      stat_max_occ
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  // The last register feeds the FIFO write port.
  // It is counted in occupancy like the other pipe stages.
  localparam int NSTG = PIPE_STAGES + 1;
  localparam int THR  = FIFO_DEPTH - AF_SLACK - 1;
  localparam logic [AW:0] THR_V = (AW+1)'(THR);

  if (THR < 1) begin : gErrThr
    $error("almost-full threshold below 1");
  end
  if ((FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gErrDepth
    $error("FIFO_DEPTH must be a power of two");
  end
  if ((PIPE_STAGES < 1) || (PIPE_STAGES > 4)) begin : gErrPipe
    $error("PIPE_STAGES must be 1..4");
  end
  if ((NUM_CH < 1) || (NUM_CH > 4)) begin : gErrCh
    $error("NUM_CH must be 1..4");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic [NSTG-1:0]   stgValid;
    logic [DATA_W-1:0] stgData [NSTG];
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [AW:0]       fifoCnt;
    logic [AW:0]       occ;
    logic              outV;
    logic [DATA_W-1:0] outD;
    logic              ovf;
    logic              afReg;
    logic              wrReq;
    logic              popEn;
    logic              isFull;
    logic              wrAcc;
    logic              wrDrop;

    // A pop on the same edge frees a slot, so a full FIFO
    // still accepts the write.
    always_comb begin
      wrReq  = stgValid[NSTG-1];
      popEn  = (fifoCnt != '0) && !out_almost_full[c];
      isFull = (fifoCnt == (AW+1)'(FIFO_DEPTH));
      wrAcc  = wrReq && (!isFull || popEn);
      wrDrop = wrReq && isFull && !popEn;
      occ    = fifoCnt;
      for (int s = 0; s < NSTG; s++) begin
        occ = occ + (AW+1)'(stgValid[s]);
      end
    end

    always_ff @(posedge clk) begin
      stgData[0] <= in_data[c*DATA_W +: DATA_W];
      for (int s = 1; s < NSTG; s++) begin
        stgData[s] <= stgData[s-1];
      end
      if (wrAcc) begin
        mem[wrPtr] <= stgData[NSTG-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stgValid <= '0;
        wrPtr    <= '0;
        rdPtr    <= '0;
        fifoCnt  <= '0;
        outV     <= 1'b0;
        outD     <= '0;
        ovf      <= 1'b0;
        afReg    <= 1'b1;
      end else begin
        stgValid <= {stgValid[NSTG-2:0], in_valid[c]};
        outV     <= popEn;
        if (wrAcc) begin
          wrPtr <= wrPtr + AW'(1);
        end
        if (popEn) begin
          outD  <= mem[rdPtr];
          rdPtr <= rdPtr + AW'(1);
        end
        unique case ({wrAcc, popEn})
          2'b10:   fifoCnt <= fifoCnt + (AW+1)'(1);
          2'b01:   fifoCnt <= fifoCnt - (AW+1)'(1);
          default: fifoCnt <= fifoCnt;
        endcase
        if (wrDrop) begin
          ovf <= 1'b1;
        end
        afReg <= (occ >= THR_V);
      end
    end

    assign out_valid[c]                 = outV;
    assign out_data[c*DATA_W +: DATA_W] = outD;
    assign overflow[c]                  = ovf;
    assign in_almost_full[c]            = afReg;

`ifdef CCIP_AF_PIPE_STATS_EN
    logic [31:0] accCnt;
    logic [7:0]  maxOcc;
    logic [31:0] cntWide;

    assign cntWide = 32'(fifoCnt);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        accCnt <= '0;
        maxOcc <= '0;
      end else begin
        if (wrAcc && (accCnt != '1)) begin
          accCnt <= accCnt + 32'd1;
        end
        if (cntWide > 32'(maxOcc)) begin
          maxOcc <= (cntWide > 32'd255) ? 8'hFF : cntWide[7:0];
        end
      end
    end

    assign stat_accepted[c*32 +: 32] = accCnt;
    assign stat_max_occ[c*8 +: 8]    = maxOcc;
`else
    assign stat_accepted[c*32 +: 32] = '0;
    assign stat_max_occ[c*8 +: 8]    = '0;
`endif
  end

endmodule

// File: tb/tb_ccip_af_pipe_reg.sv
// tb_ccip_af_pipe_reg: directed bench for ccip_af_pipe_reg at default params.
// Checks latency, almost-full timing, overflow, independence, reset and stats.
module tb_ccip_af_pipe_reg;

  localparam int NCH = 2;
  localparam int DW  = 600;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      in_valid;
  logic [NCH*DW-1:0]   in_data;
  logic [NCH-1:0]      in_almost_full;
  logic [NCH-1:0]      out_valid;
  logic [NCH*DW-1:0]   out_data;
  logic [NCH-1:0]      out_almost_full;
  logic [NCH-1:0]      overflow;
  logic [NCH*32-1:0]   stat_accepted;
  logic [NCH*8-1:0]    stat_max_occ;

  int nAssert = 0;
  int nFail   = 0;
  int riseEdge;
  int nSent;
  int extra;
  int nRx;
  int nRx1;
  int gaps;
  int ch1Out;
  int af0Seen;
  int af1Seen;
  int anyOut;
  logic [63:0] expAcc;
  logic [63:0] expMax;

  ccip_af_pipe_reg dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_almost_full  (in_almost_full),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_almost_full (out_almost_full),
    .overflow        (overflow),
    .stat_accepted   (stat_accepted),
    .stat_max_occ    (stat_max_occ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int c, input logic v, input logic [63:0] d);
    in_valid[c]         = v;
    in_data[c*DW +: DW] = DW'(d);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    in_valid        = '0;
    in_data         = '0;
    out_almost_full = '0;
    reset           = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_af", 64'(in_almost_full), 64'd3);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_out_data", out_data[63:0], 64'd0);
    chk("rst_stat_acc", stat_accepted[63:0], 64'd0);
    reset = 1'b0;
    tick();
    chk("af_after_rst", 64'(in_almost_full), 64'd0);

    // single request: 4-edge latency, one-cycle pulse
    setReq(0, 1'b1, 64'hA5);
    tick();
    setReq(0, 1'b0, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("single_early", 64'(out_valid), 64'd0);
    end
    tick();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", out_data[63:0], 64'hA5);
    tick();
    chk("single_pulse", 64'(out_valid), 64'd0);
    chk("single_hold", out_data[63:0], 64'hA5);
    chk("single_af", 64'(in_almost_full), 64'd0);

    // fill under backpressure, compliant upstream
    out_almost_full = 2'b01;
    riseEdge = -1;
    nSent    = 0;
    extra    = 0;
    for (int e = 0; e < 40; e++) begin
      if ((riseEdge < 0) || (extra < 8)) begin
        setReq(0, 1'b1, 64'h100 + 64'(nSent));
        nSent++;
        if (riseEdge >= 0) extra++;
      end else begin
        setReq(0, 1'b0, 64'd0);
      end
      tick();
      if ((riseEdge < 0) && in_almost_full[0]) riseEdge = e;
    end
    setReq(0, 1'b0, 64'd0);
    chk("fill_rise_edge", 64'(riseEdge), 64'd23);
    chk("fill_sent", 64'(nSent), 64'd32);
    for (int i = 0; i < 5; i++) tick();
    chk("fill_no_ovf", 64'(overflow), 64'd0);
    chk("fill_af_high", 64'(in_almost_full[0]), 64'd1);
    out_almost_full = 2'b00;
    nRx  = 0;
    gaps = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (out_valid[0]) begin
        chk("fill_order", out_data[63:0], 64'h100 + 64'(nRx));
        nRx++;
      end else if ((nRx > 0) && (nRx < 32)) begin
        gaps++;
      end
    end
    chk("fill_count", 64'(nRx), 64'd32);
    chk("fill_gaps", 64'(gaps), 64'd0);
    chk("fill_af_low", 64'(in_almost_full), 64'd0);
    chk("fill_ovf_end", 64'(overflow), 64'd0);

    // overflow: upstream ignores almost-full
    out_almost_full = 2'b01;
    for (int e = 0; e < 45; e++) begin
      if (e < 40) setReq(0, 1'b1, 64'h200 + 64'(e));
      else setReq(0, 1'b0, 64'd0);
      tick();
      if (e == 34) chk("ovf_before", 64'(overflow[0]), 64'd0);
      if (e == 35) chk("ovf_set", 64'(overflow[0]), 64'd1);
    end
    chk("ovf_sticky", 64'(overflow), 64'd1);
    out_almost_full = 2'b00;
    nRx = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (out_valid[0]) begin
        chk("ovf_order", out_data[63:0], 64'h200 + 64'(nRx));
        nRx++;
      end
    end
    chk("ovf_count", 64'(nRx), 64'd32);
    chk("ovf_sticky_end", 64'(overflow), 64'd1);

    // reset mid-operation with 10 buffered entries
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("ovf_cleared", 64'(overflow), 64'd0);
    out_almost_full = 2'b01;
    for (int e = 0; e < 10; e++) begin
      setReq(0, 1'b1, 64'h50 + 64'(e));
      tick();
    end
    setReq(0, 1'b0, 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_af_before", 64'(in_almost_full), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_af_ones", 64'(in_almost_full), 64'd3);
    chk("mid_out_data", out_data[63:0], 64'd0);
    tick();
    tick();
    chk("mid_af_hold", 64'(in_almost_full), 64'd3);
    reset = 1'b0;
    out_almost_full = 2'b00;
    tick();
    chk("mid_af_first_edge", 64'(in_almost_full), 64'd0);
    anyOut = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (out_valid != '0) anyOut++;
    end
    chk("mid_no_output", 64'(anyOut), 64'd0);

    // channel independence
    out_almost_full = 2'b10;
    nRx     = 0;
    gaps    = 0;
    ch1Out  = 0;
    af0Seen = 0;
    af1Seen = 0;
    for (int t = 0; t < 115; t++) begin
      if (t < 100) setReq(0, 1'b1, 64'h300 + 64'(t));
      else setReq(0, 1'b0, 64'd0);
      if (t < 5) setReq(1, 1'b1, 64'h400 + 64'(t));
      else setReq(1, 1'b0, 64'd0);
      tick();
      if (out_valid[0]) begin
        chk("ind_order", out_data[63:0], 64'h300 + 64'(nRx));
        nRx++;
      end else if ((nRx > 0) && (nRx < 100)) begin
        gaps++;
      end
      if (out_valid[1]) ch1Out++;
      if (in_almost_full[0]) af0Seen++;
      if (in_almost_full[1]) af1Seen++;
    end
    chk("ind_count", 64'(nRx), 64'd100);
    chk("ind_gaps", 64'(gaps), 64'd0);
    chk("ind_ch1_held", 64'(ch1Out), 64'd0);
    chk("ind_af0", 64'(af0Seen), 64'd0);
    chk("ind_af1", 64'(af1Seen), 64'd0);
    out_almost_full = 2'b00;
    nRx1 = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (out_valid[1]) begin
        chk("ind_ch1_order", out_data[DW +: 64], 64'h400 + 64'(nRx1));
        nRx1++;
      end
    end
    chk("ind_ch1_count", 64'(nRx1), 64'd5);

    // statistics
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_almost_full = 2'b01;
    for (int e = 0; e < 12; e++) begin
      setReq(0, 1'b1, 64'h600 + 64'(e));
      tick();
    end
    setReq(0, 1'b0, 64'd0);
    for (int i = 0; i < 8; i++) tick();
`ifdef CCIP_AF_PIPE_STATS_EN
    expAcc = 64'd12;
    expMax = 64'd12;
`else
    expAcc = 64'd0;
    expMax = 64'd0;
`endif
    chk("stat_acc0", 64'(stat_accepted[31:0]), expAcc);
    chk("stat_max0", 64'(stat_max_occ[7:0]), expMax);
    chk("stat_acc1", 64'(stat_accepted[63:32]), 64'd0);
    chk("stat_max1", 64'(stat_max_occ[15:8]), 64'd0);
    chk("stat_af", 64'(in_almost_full), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
